// File: rtl/reg_file_if.sv
// Bundles the write-back, issue and register-read signals of the 8x16 register file.
// Handshake: issue_en is the issuer's request; stall is the not-ready reply; an issue is accepted only on a cycle where issue_en=1 and stall=0.
interface reg_file_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  wr_en;
    logic [2:0]            wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  issue_en;
    logic [2:0]            issue_dst;
    logic [2:0]            issue_src;
    logic [DATA_WIDTH-1:0] reg_out [8];
    logic [7:0]            busy;
    logic                  stall;
    logic                  wr_err;

    modport master (
        output wr_en, wr_addr, wr_data, issue_en, issue_dst, issue_src,
        input  reg_out, busy, stall, wr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, issue_en, issue_dst, issue_src,
        output reg_out, busy, stall, wr_err
    );
endinterface

// File: rtl/reg_file_8x16.sv
// 8-entry register file with a destination-busy scoreboard feeding the 8:1 operand mux.
// Optional write-through to reg_out (and stall relief for a source written this cycle) when REGFILE_BYPASS_EN is defined.
module reg_file_8x16 #(
    parameter int                    DATA_WIDTH = 16,
    parameter bit                    ZERO_REG   = 1'b1,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  bus
);
    logic [DATA_WIDTH-1:0] regs [8];
    logic [7:0]            busy_q;
    logic [7:0]            busy_d;
    logic                  wr_err_q;
    logic                  zero_wr;
    logic                  zero_dst;
    logic                  issue_ok;

    assign zero_wr  = ZERO_REG && (bus.wr_addr == 3'd0);
    assign zero_dst = ZERO_REG && (bus.issue_dst == 3'd0);

`ifdef REGFILE_BYPASS_EN
    logic wr_hits_src;
    assign wr_hits_src = bus.wr_en && (bus.wr_addr == bus.issue_src);
    assign bus.stall   = bus.issue_en && busy_q[bus.issue_src] && !wr_hits_src;
`else
    assign bus.stall   = bus.issue_en && busy_q[bus.issue_src];
`endif

    assign issue_ok = bus.issue_en && !bus.stall && !zero_dst;

    // Clear for the write first, then set for the issue, so a new issue to the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (bus.wr_en) begin
            busy_d[bus.wr_addr] = 1'b0;
        end
        if (issue_ok) begin
            busy_d[bus.issue_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= (ZERO_REG && i == 0) ? '0 : RESET_VAL;
            end
            busy_q   <= 8'h00;
            wr_err_q <= 1'b0;
        end else begin
            if (bus.wr_en && !zero_wr) begin
                regs[bus.wr_addr] <= bus.wr_data;
            end
            busy_q <= busy_d;
            if (bus.wr_en && !busy_q[bus.wr_addr] && !zero_wr) begin
                wr_err_q <= 1'b1;
            end
        end
    end

    for (genvar n = 0; n < 8; n++) begin : g_out
        if (ZERO_REG && n == 0) begin : g_zero
            assign bus.reg_out[n] = '0;
        end else begin : g_reg
`ifdef REGFILE_BYPASS_EN
            assign bus.reg_out[n] = (bus.wr_en && bus.wr_addr == 3'(n)) ? bus.wr_data : regs[n];
`else
            assign bus.reg_out[n] = regs[n];
`endif
        end
    end

    assign bus.busy   = busy_q;
    assign bus.wr_err = wr_err_q;
endmodule

// File: tb/tb_reg_file_8x16.sv
// Directed and randomized bench for reg_file_8x16 against a behavioural model of registers, busy bits and the sticky error.
module tb_reg_file_8x16;
    localparam int W  = 16;
    localparam bit ZR = 1'b1;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_if #(.DATA_WIDTH(W)) bus ();

    reg_file_8x16 #(
        .DATA_WIDTH(W),
        .ZERO_REG  (ZR),
        .RESET_VAL (16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // reference model
    logic [W-1:0] m_regs [8];
    bit           m_busy [8];
    bit           m_err;
    logic [W-1:0] exp_q [$];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] model_busy();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = 16'h0000;
            m_busy[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    task automatic idle();
        bus.wr_en     = 1'b0;
        bus.wr_addr   = 3'd0;
        bus.wr_data   = '0;
        bus.issue_en  = 1'b0;
        bus.issue_dst = 3'd0;
        bus.issue_src = 3'd0;
    endtask

    task automatic check_state();
        logic [W-1:0] e;
        chk("busy", bus.busy, model_busy());
        chk("wr_err", bus.wr_err, m_err);
        for (int n = 0; n < 8; n++) exp_q.push_back(m_regs[n]);
        for (int n = 0; n < 8; n++) begin
            e = exp_q.pop_front();
            chk($sformatf("reg_out%0d", n), bus.reg_out[n], e);
        end
    endtask

    // driver: one clock of write/issue activity, comb checks before the edge, state checks after
    task automatic cycle(input bit we, input logic [2:0] wa, input logic [W-1:0] wd,
                         input bit ie, input logic [2:0] dst, input logic [2:0] src);
        bit           exp_stall;
        logic [W-1:0] e;
        bus.wr_en     = we;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        bus.issue_en  = ie;
        bus.issue_dst = dst;
        bus.issue_src = src;
        #1;
        exp_stall = ie && m_busy[src] && !(BYP && we && wa == src);
        chk("stall", bus.stall, exp_stall);
        for (int n = 0; n < 8; n++) begin
            if (BYP && we && wa == 3'(n) && !(ZR && n == 0)) exp_q.push_back(wd);
            else exp_q.push_back(m_regs[n]);
        end
        for (int n = 0; n < 8; n++) begin
            e = exp_q.pop_front();
            chk($sformatf("reg_out%0d_comb", n), bus.reg_out[n], e);
        end
        @(posedge clk);
        if (we) begin
            if (!m_busy[wa] && !(ZR && wa == 3'd0)) m_err = 1'b1;
            if (!(ZR && wa == 3'd0)) m_regs[wa] = wd;
            m_busy[wa] = 1'b0;
        end
        if (ie && !exp_stall && !(ZR && dst == 3'd0)) m_busy[dst] = 1'b1;
        #1;
        idle();
        #1;
        check_state();
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.wr_en     = 1'($urandom_range(0, 1));
        bus.wr_addr   = 3'($urandom_range(0, 7));
        bus.wr_data   = 16'($urandom);
        bus.issue_en  = 1'($urandom_range(0, 1));
        bus.issue_dst = 3'($urandom_range(0, 7));
        bus.issue_src = 3'($urandom_range(0, 7));
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        idle();
        #1;
        check_state();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        do_reset();

        // random writes, then reset must clear everything
        for (int i = 0; i < 6; i++) cycle(1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 1'b0, 3'd0, 3'd0);
        do_reset();
        chk("reset_busy", bus.busy, 8'h00);
        chk("reset_err", bus.wr_err, 1'b0);
        chk("reset_r3", bus.reg_out[3], 16'h0000);

        // issue then write-back
        cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd0);
        chk("issue_busy", bus.busy, 8'h08);
        cycle(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd0);
        chk("wb_r3", bus.reg_out[3], 16'hBEEF);
        chk("wb_busy", bus.busy, 8'h00);

        // RAW hazard stall and retry
        cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 3'd0);
        cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd5);
        chk("hazard_busy", bus.busy, 8'h20);
        cycle(1'b1, 3'd5, 16'h5555, 1'b0, 3'd0, 3'd0);
        cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd5);
        chk("retry_busy", bus.busy, 8'h04);

        // same-register write and issue
        cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 3'd0);
        cycle(1'b1, 3'd4, 16'hA5A5, 1'b1, 3'd4, 3'd0);
        chk("same_r4", bus.reg_out[4], 16'hA5A5);
        chk("same_busy", bus.busy, 8'h14);

        // zero register and sticky write error
        cycle(1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 3'd0);
        chk("zero_r0", bus.reg_out[0], 16'h0000);
        chk("zero_err", bus.wr_err, 1'b0);
        cycle(1'b1, 3'd6, 16'h6666, 1'b0, 3'd0, 3'd0);
        chk("spurious_err", bus.wr_err, 1'b1);
        cycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0);
        cycle(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0);
        chk("sticky_err", bus.wr_err, 1'b1);

        // source written in the same cycle it is checked
        cycle(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 3'd0);
        cycle(1'b1, 3'd5, 16'h7777, 1'b1, 3'd7, 3'd5);
        chk("src_wr_busy", bus.busy, BYP ? 8'h94 : 8'h14);

        // write-through visibility (comb check inside cycle), then new value after the edge
        cycle(1'b1, 3'd1, 16'h1234, 1'b0, 3'd0, 3'd0);
        chk("bypass_r1", bus.reg_out[1], 16'h1234);

        do_reset();
        chk("err_cleared", bus.wr_err, 1'b0);

        // randomized traffic with occasional mid-sequence reset
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            else cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                       1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
